// File: rtl/onehot_encoder_8to3.sv
// Sticky 8-input request collector that presents pending requests one at a time,
// in fixed priority order, as a 3-bit index on a registered valid/ready output.
module onehot_encoder_8to3 #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [2:0] code_reg;
  logic [7:0] pending_reg;
  logic       overflow_reg;

  logic       acc;
  logic [7:0] clr;
  logic [7:0] pend_eff;
  logic [2:0] sel;

  assign acc = (state_reg == PRESENT) && out_ready;

  // Only the bit currently on out_code is retired by a handshake.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_clr
      assign clr[gi] = acc && (code_reg == 3'(gi));
    end
  endgenerate

  assign pend_eff = pending_reg & ~clr;

  // Highest-priority set bit: the last match written in the scan wins.
  always_comb begin
    sel = 3'd0;
    if (LOW_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (pend_eff[i]) sel = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (pend_eff[i]) sel = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      code_reg     <= 3'd0;
      pending_reg  <= 8'd0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= pend_eff | req;
      overflow_reg <= |(req & pend_eff);
      // A presented code is held until taken; new selection only on idle or accept.
      if (state_reg == IDLE || acc) begin
        if (pend_eff != 8'd0) begin
          state_reg <= PRESENT;
          code_reg  <= sel;
        end else begin
          state_reg <= IDLE;
        end
      end
    end
  end

  assign out_valid = (state_reg == PRESENT);
  assign out_code  = code_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_onehot_encoder_8to3.sv
// Bench for onehot_encoder_8to3: both priority orders side by side, with a
// scoreboard of expected accepted codes plus directed register checks.
module tb_onehot_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       out_ready;

  logic       lo_valid, hi_valid;
  logic [2:0] lo_code, hi_code;
  logic [7:0] lo_pending, hi_pending;
  logic       lo_overflow, hi_overflow;

  int checks = 0;
  int errors = 0;

  logic [2:0] q_lo[$];
  logic [2:0] q_hi[$];

  onehot_encoder_8to3 #(.LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(lo_valid), .out_code(lo_code), .pending(lo_pending), .overflow(lo_overflow)
  );

  onehot_encoder_8to3 #(.LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
    .out_valid(hi_valid), .out_code(hi_code), .pending(hi_pending), .overflow(hi_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after posedge, so at negedge they reflect what the next edge samples.
  always @(negedge clk) begin
    if (rst_n && lo_valid && out_ready) begin
      if (q_lo.size() == 0) check("lo_sb_unexpected", 32'(lo_code), 32'hFFFF_FFFF);
      else begin
        automatic logic [2:0] e = q_lo.pop_front();
        $display("lo accept code=%0d expected=%0d", lo_code, e);
        check("lo_sb_code", 32'(lo_code), 32'(e));
      end
    end
    if (rst_n && hi_valid && out_ready) begin
      if (q_hi.size() == 0) check("hi_sb_unexpected", 32'(hi_code), 32'hFFFF_FFFF);
      else begin
        automatic logic [2:0] e = q_hi.pop_front();
        $display("hi accept code=%0d expected=%0d", hi_code, e);
        check("hi_sb_code", 32'(hi_code), 32'(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 8'hFF; out_ready = 1'b0;
    step(); step(); step();
    check("rst_pending", 32'(lo_pending), 32'h00);
    check("rst_valid", 32'(lo_valid), 32'h0);
    check("rst_code", 32'(lo_code), 32'h0);
    check("rst_overflow", 32'(lo_overflow), 32'h0);
    check("rst_hi_pending", 32'(hi_pending), 32'h00);
    rst_n = 1'b1; req = 8'h00;
    step();
    check("post_rst_pending", 32'(lo_pending), 32'h00);
    check("post_rst_valid", 32'(lo_valid), 32'h0);

    // Ordering: 0x24 drains 2 then 5 (low first) or 5 then 2 (high first)
    out_ready = 1'b1; req = 8'h24;
    q_lo.push_back(3'd2); q_lo.push_back(3'd5);
    q_hi.push_back(3'd5); q_hi.push_back(3'd2);
    step(); req = 8'h00;
    check("ord_e1_pending", 32'(lo_pending), 32'h24);
    check("ord_e1_valid", 32'(lo_valid), 32'h0);
    step();
    check("ord_e2_valid", 32'(lo_valid), 32'h1);
    check("ord_e2_code", 32'(lo_code), 32'd2);
    check("ord_e2_hi_code", 32'(hi_code), 32'd5);
    step();
    check("ord_e3_code", 32'(lo_code), 32'd5);
    check("ord_e3_pending", 32'(lo_pending), 32'h20);
    step();
    check("ord_e4_valid", 32'(lo_valid), 32'h0);
    check("ord_e4_pending", 32'(lo_pending), 32'h00);

    // Stall: code 7 held while a higher-priority bit 0 arrives
    out_ready = 1'b0; req = 8'h80;
    q_lo.push_back(3'd7); q_hi.push_back(3'd7);
    step(); req = 8'h00;
    step();
    check("stall_code7", 32'(lo_code), 32'd7);
    req = 8'h01;
    q_lo.push_back(3'd0); q_hi.push_back(3'd0);
    step(); req = 8'h00;
    step();
    check("stall_hold_code", 32'(lo_code), 32'd7);
    check("stall_hold_valid", 32'(lo_valid), 32'h1);
    check("stall_pending", 32'(lo_pending), 32'h81);
    out_ready = 1'b1;
    step();
    check("stall_next_code", 32'(lo_code), 32'd0);
    check("stall_next_pending", 32'(lo_pending), 32'h01);
    step();
    check("stall_done_valid", 32'(lo_valid), 32'h0);

    // Overflow on an already-pending bit, then re-request at accept
    out_ready = 1'b0; req = 8'h08;
    q_lo.push_back(3'd3); q_hi.push_back(3'd3);
    step(); req = 8'h00;
    step();
    check("ovf_code3", 32'(lo_code), 32'd3);
    req = 8'h08;
    step(); req = 8'h00;
    check("ovf_pulse", 32'(lo_overflow), 32'h1);
    check("ovf_pending", 32'(lo_pending), 32'h08);
    step();
    check("ovf_clear", 32'(lo_overflow), 32'h0);
    check("ovf_pending_kept", 32'(lo_pending), 32'h08);
    out_ready = 1'b1; req = 8'h08;
    q_lo.push_back(3'd3); q_hi.push_back(3'd3);
    step(); req = 8'h00; out_ready = 1'b0;
    check("reacc_overflow", 32'(lo_overflow), 32'h0);
    check("reacc_pending3", 32'(lo_pending[3]), 32'h1);
    step();
    check("reacc_valid", 32'(lo_valid), 32'h1);
    check("reacc_code", 32'(lo_code), 32'd3);
    out_ready = 1'b1;
    step();
    check("reacc_done_valid", 32'(lo_valid), 32'h0);

    // Both priority orders on 0x81
    req = 8'h81;
    q_hi.push_back(3'd7); q_hi.push_back(3'd0);
    q_lo.push_back(3'd0); q_lo.push_back(3'd7);
    step(); req = 8'h00;
    step();
    check("hf_first", 32'(hi_code), 32'd7);
    step();
    check("hf_second", 32'(hi_code), 32'd0);
    step();
    check("hf_done", 32'(hi_valid), 32'h0);

    // Mid-stream reset discards code 7 on presentation and the pending bit 0
    req = 8'h81;
    step(); req = 8'h00;
    step();
    check("mr_code7", 32'(hi_code), 32'd7);
    rst_n = 1'b0;
    step(); rst_n = 1'b1;
    check("mr_valid", 32'(hi_valid), 32'h0);
    check("mr_pending", 32'(hi_pending), 32'h00);
    step(); step();
    check("mr_no_code0", 32'(hi_valid), 32'h0);
    check("mr_lo_idle", 32'(lo_valid), 32'h0);

    check("lo_sb_drained", 32'(q_lo.size()), 32'd0);
    check("hi_sb_drained", 32'(q_hi.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
